dsp_core_ctrl: RTL and testbench

- Parametrised frame controller between the serial receive/transmit channels and the FFT/FIR compute engines.
- Accepts a header word that selects mode and frame length, then buffers N samples and launches the selected engine with a start pulse.
- Waits for the engine's done, then streams the results out word by word under tx_done handshake.
- Generalises the fixed 64-point FFT controller: variable length, three modes, error reporting.

---
 rtl/dsp_core_pkg.sv | 24 ++
 rtl/dsp_core_outsel.sv | 46 ++++
 rtl/dsp_core_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dsp_core_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_core_pkg.sv
// rtl/dsp_core_pkg.sv - shared states, mode/error codes and header layout for the DSP frame controller
package dsp_core_pkg;

  typedef enum logic [2:0] {IDLE, RECV, START, WAIT, XMIT} core_state_t;

  localparam logic [1:0] MODE_FFT = 2'b00;
  localparam logic [1:0] MODE_FIR = 2'b01;
  localparam logic [1:0] MODE_BYP = 2'b10;
  localparam logic [1:0] MODE_BAD = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_MODE    = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam int HDR_MODE_LSB = 0;
  localparam int HDR_LEN_LSB  = 8;

  // Index of the final output word: 2*(len+1)-1 for FFT, len otherwise.
  function automatic logic [8:0] last_word_idx(input logic [1:0] mode, input logic [7:0] len);
    return (mode == MODE_FFT) ? {len, 1'b1} : {1'b0, len};
  endfunction

endpackage

// File: rtl/dsp_core_outsel.sv
// rtl/dsp_core_outsel.sv - maps (mode, len, word index) to one transmit word
// FFT words past len come from the imaginary half starting at MAX_N.
module dsp_core_outsel
  import dsp_core_pkg::*;
#(
  parameter int DW    = 16,
  parameter int MAX_N = 64
) (
  input  logic [1:0]                 mode,
  input  logic [$clog2(MAX_N)-1:0]   len,
  input  logic [$clog2(MAX_N):0]     k,
  input  logic [2*MAX_N*DW-1:0]      res_flat,
  input  logic [MAX_N*DW-1:0]        cache_flat,
  output logic [DW-1:0]              word
);

  localparam int CW = $clog2(MAX_N);
  localparam int IW = CW + 1;

  logic [DW-1:0] res_w   [2*MAX_N];
  logic [DW-1:0] cache_w [MAX_N];
  logic [IW-1:0] len_x;
  logic [IW-1:0] imag_idx;

  for (genvar i = 0; i < 2*MAX_N; i++) begin : g_res
    assign res_w[i] = res_flat[i*DW +: DW];
  end

  for (genvar i = 0; i < MAX_N; i++) begin : g_cache
    assign cache_w[i] = cache_flat[i*DW +: DW];
  end

  assign len_x    = {1'b0, len};
  assign imag_idx = k - len_x - IW'(1) + IW'(MAX_N);

  always_comb begin
    word = '0;
    case (mode)
      MODE_FFT: word = (k <= len_x) ? res_w[k] : res_w[imag_idx];
      MODE_FIR: word = res_w[k];
      MODE_BYP: word = cache_w[k[CW-1:0]];
      default:  word = '0;
    endcase
  end

endmodule

// File: rtl/dsp_core_ctrl.sv
// rtl/dsp_core_ctrl.sv - header decode, sample cache, engine launch and result streaming
// Optional engine watchdog in WAIT enabled by DSP_CORE_TIMEOUT_EN.
module dsp_core_ctrl
  import dsp_core_pkg::*;
#(
  parameter int DW             = 16,
  parameter int MAX_N          = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic [DW-1:0]           data_in,
  input  logic                    data_in_valid,
  input  logic                    tx_done,
  output logic [DW-1:0]           data_out,
  output logic                    data_out_valid,
  output logic                    core_busy,
  output logic [1:0]              eng_mode,
  output logic [7:0]              eng_len,
  output logic                    eng_start,
  input  logic                    eng_done,
  output logic [MAX_N*DW-1:0]     cache_flat,
  input  logic [2*MAX_N*DW-1:0]   res_flat,
  output logic [1:0]              err
);

  localparam int CW = $clog2(MAX_N);
  localparam int IW = CW + 1;
  localparam logic [7:0] LEN_MAX = 8'(MAX_N - 1);

  core_state_t   state, state_n;
  logic [8:0]    cnt, cnt_n;
  logic [DW-1:0] dout_n;
  logic          dvalid_n;
  logic [1:0]    mode_n, err_n;
  logic [7:0]    len_n;
  logic          cache_we;
  logic [1:0]    hdr_mode;
  logic [7:0]    hdr_len;
  logic [IW-1:0] sel_k;
  logic [DW-1:0] sel_word;
  logic          wd_expired;
  logic [DW-1:0] cache_mem [MAX_N];

  assign hdr_mode = data_in[HDR_MODE_LSB +: 2];

  if (DW >= HDR_LEN_LSB + 8) begin : g_hdr_full
    assign hdr_len = data_in[HDR_LEN_LSB +: 8];
  end else begin : g_hdr_narrow
    assign hdr_len = 8'(data_in[DW-1:HDR_LEN_LSB]);
  end

  assign core_busy = (state != IDLE);
  assign eng_start = (state == START);

  for (genvar i = 0; i < MAX_N; i++) begin : g_cache_flat
    assign cache_flat[i*DW +: DW] = cache_mem[i];
  end

  // Selector looks one word ahead while streaming, and at word 0 otherwise.
  assign sel_k = (state == XMIT) ? (cnt[IW-1:0] + IW'(1)) : '0;

  dsp_core_outsel #(.DW(DW), .MAX_N(MAX_N)) u_outsel (
    .mode       (eng_mode),
    .len        (eng_len[CW-1:0]),
    .k          (sel_k),
    .res_flat   (res_flat),
    .cache_flat (cache_flat),
    .word       (sel_word)
  );

`ifdef DSP_CORE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wd_cnt <= '0;
    end else if (state != WAIT || eng_done) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + TW'(1);
    end
  end

  assign wd_expired = (state == WAIT) && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dout_n   = data_out;
    dvalid_n = data_out_valid;
    mode_n   = eng_mode;
    len_n    = eng_len;
    err_n    = err;
    cache_we = 1'b0;
    case (state)
      IDLE: begin
        if (data_in_valid) begin
          if (hdr_mode == MODE_BAD) begin
            err_n = ERR_MODE;
          end else if (hdr_len > LEN_MAX) begin
            err_n = ERR_LEN;
          end else begin
            mode_n  = hdr_mode;
            len_n   = hdr_len;
            err_n   = ERR_NONE;
            cnt_n   = '0;
            state_n = RECV;
          end
        end
      end
      RECV: begin
        if (data_in_valid) begin
          cache_we = 1'b1;
          if (cnt == {1'b0, eng_len}) begin
            cnt_n = '0;
            if (eng_mode == MODE_BYP) begin
              // Sample 0 is still being written when len is 0, so forward it.
              state_n  = XMIT;
              dvalid_n = 1'b1;
              dout_n   = (cnt == 9'd0) ? data_in : sel_word;
            end else begin
              state_n = START;
            end
          end else begin
            cnt_n = cnt + 9'd1;
          end
        end
      end
      START: state_n = WAIT;
      WAIT: begin
        if (eng_done) begin
          state_n  = XMIT;
          dvalid_n = 1'b1;
          dout_n   = sel_word;
        end else if (wd_expired) begin
          state_n = IDLE;
          err_n   = ERR_TIMEOUT;
        end
      end
      XMIT: begin
        if (tx_done && data_out_valid) begin
          if (cnt == last_word_idx(eng_mode, eng_len)) begin
            dvalid_n = 1'b0;
            cnt_n    = '0;
            state_n  = IDLE;
          end else begin
            cnt_n  = cnt + 9'd1;
            dout_n = sel_word;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state          <= IDLE;
      cnt            <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      eng_mode       <= MODE_FFT;
      eng_len        <= '0;
      err            <= ERR_NONE;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      data_out       <= dout_n;
      data_out_valid <= dvalid_n;
      eng_mode       <= mode_n;
      eng_len        <= len_n;
      err            <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (cache_we) begin
      cache_mem[cnt[CW-1:0]] <= data_in;
    end
  end

endmodule

// File: tb/tb_dsp_core_ctrl.sv
// tb/tb_dsp_core_ctrl.sv - directed self-checking bench for dsp_core_ctrl
// Timeout cases are compiled in when DSP_CORE_TIMEOUT_EN is defined.
module tb_dsp_core_ctrl;

  localparam int DW    = 16;
  localparam int MAX_N = 64;

  logic                  clk = 1'b0;
  logic                  rstb = 1'b0;
  logic [DW-1:0]         data_in = '0;
  logic                  data_in_valid = 1'b0;
  logic                  tx_done = 1'b0;
  logic [DW-1:0]         data_out;
  logic                  data_out_valid;
  logic                  core_busy;
  logic [1:0]            eng_mode;
  logic [7:0]            eng_len;
  logic                  eng_start;
  logic                  eng_done = 1'b0;
  logic [MAX_N*DW-1:0]   cache_flat;
  logic [2*MAX_N*DW-1:0] res_flat;
  logic [1:0]            err;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  logic [15:0] samp [MAX_N];

  dsp_core_ctrl #(.DW(DW), .MAX_N(MAX_N), .TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rstb           (rstb),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .tx_done        (tx_done),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .core_busy      (core_busy),
    .eng_mode       (eng_mode),
    .eng_len        (eng_len),
    .eng_start      (eng_start),
    .eng_done       (eng_done),
    .cache_flat     (cache_flat),
    .res_flat       (res_flat),
    .err            (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (eng_start) start_cnt <= start_cnt + 1;

  typedef struct {
    logic [15:0] hdr;
    logic [1:0]  err;
    logic        busy;
    logic [1:0]  mode;
    logic [7:0]  len;
  } hdr_vec_t;

  hdr_vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic send(input logic [15:0] w);
    data_in = w;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
  endtask

  function automatic logic [15:0] exp_word(input logic [1:0] mode, input int len, input int k);
    if (mode == 2'b10) return samp[k];
    if (mode == 2'b01 || k <= len) return 16'h1000 + 16'(k);
    return 16'h2000 + 16'(k - len - 1);
  endfunction

  task automatic wait_start();
    int t;
    t = 0;
    while (!eng_start && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("eng_start_seen", 32'(eng_start), 32'd1);
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!data_out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("valid_seen", 32'(data_out_valid), 32'd1);
  endtask

  // Streams all words; stall_k >= 0 holds tx_done low for 20 cycles at that word.
  task automatic drain(input logic [1:0] mode, input int len, input int stall_k);
    int oc;
    int unstable;
    logic [15:0] held;
    oc = (mode == 2'b00) ? 2*(len+1) : len+1;
    wait_valid();
    for (int k = 0; k < oc; k++) begin
      chk($sformatf("word_%0d", k), 32'(data_out), 32'(exp_word(mode, len, k)));
      if (k == stall_k) begin
        unstable = 0;
        held = data_out;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (data_out !== held || data_out_valid !== 1'b1) unstable++;
        end
        chk("stall_stable", 32'(unstable), 32'd0);
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
    chk("valid_after_last", 32'(data_out_valid), 32'd0);
    chk("busy_after_last", 32'(core_busy), 32'd0);
  endtask

  task automatic load_frame(input logic [15:0] hdr, input int done_dly);
    int len;
    len = int'(hdr[15:8]);
    send(hdr);
    for (int i = 0; i <= len; i++) send(samp[i]);
    if (hdr[1:0] != 2'b10) begin
      wait_start();
      repeat (done_dly) @(negedge clk);
      eng_done = 1'b1;
      @(negedge clk);
      eng_done = 1'b0;
    end
  endtask

  initial begin
    int s0;
    for (int i = 0; i < MAX_N; i++) begin
      res_flat[i*DW +: DW]         = 16'h1000 + 16'(i);
      res_flat[(MAX_N+i)*DW +: DW] = 16'h2000 + 16'(i);
    end
    vecs[0] = '{16'h0003, 2'b01, 1'b0, 2'b00, 8'd0};
    vecs[1] = '{16'h4000, 2'b10, 1'b0, 2'b00, 8'd0};
    vecs[2] = '{16'hFF01, 2'b10, 1'b0, 2'b00, 8'd0};
    vecs[3] = '{16'h4003, 2'b01, 1'b0, 2'b00, 8'd0};
    vecs[4] = '{16'h3F00, 2'b00, 1'b1, 2'b00, 8'd63};
    vecs[5] = '{16'h0301, 2'b00, 1'b1, 2'b01, 8'd3};
    vecs[6] = '{16'h0102, 2'b00, 1'b1, 2'b10, 8'd1};
    vecs[7] = '{16'h0000, 2'b00, 1'b1, 2'b00, 8'd0};

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_busy", 32'(core_busy), 32'd0);
    chk("rst_valid", 32'(data_out_valid), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_start", 32'(eng_start), 32'd0);
    chk("rst_mode_len", {22'd0, eng_mode, eng_len}, 32'd0);
    @(negedge clk);
    rstb = 1'b1;

    // Header decode table
    for (int v = 0; v < 8; v++) begin
      do_reset();
      send(vecs[v].hdr);
      chk($sformatf("hdr%0d_err", v), 32'(err), 32'(vecs[v].err));
      chk($sformatf("hdr%0d_busy", v), 32'(core_busy), 32'(vecs[v].busy));
      chk($sformatf("hdr%0d_mode", v), 32'(eng_mode), 32'(vecs[v].mode));
      chk($sformatf("hdr%0d_len", v), 32'(eng_len), 32'(vecs[v].len));
    end

    // Bad header then good header clears err; eng_done ignored in RECV
    do_reset();
    send(16'h0003);
    chk("bad_then_err", 32'(err), 32'd1);
    send(16'h0301);
    chk("good_clears_err", 32'(err), 32'd0);
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    chk("done_in_recv_valid", 32'(data_out_valid), 32'd0);
    chk("done_in_recv_busy", 32'(core_busy), 32'd1);
    do_reset();

    // FFT, 64 points
    for (int i = 0; i < MAX_N; i++) samp[i] = 16'(i);
    s0 = start_cnt;
    load_frame(16'h3F00, 10);
    drain(2'b00, 63, -1);
    chk("fft64_starts", 32'(start_cnt - s0), 32'd1);

    // FIR, 4 points, with a 20-cycle tx_done stall at word 1
    samp[0] = 16'hAAAA; samp[1] = 16'hBBBB; samp[2] = 16'hCCCC; samp[3] = 16'hDDDD;
    s0 = start_cnt;
    load_frame(16'h0301, 3);
    chk("fir_mode", 32'(eng_mode), 32'd1);
    chk("fir_len", 32'(eng_len), 32'd3);
    for (int i = 0; i < 4; i++) chk($sformatf("fir_cache%0d", i), 32'(cache_flat[i*DW +: DW]), 32'(samp[i]));
    drain(2'b01, 3, 1);
    chk("fir_starts", 32'(start_cnt - s0), 32'd1);

    // Bypass, data_in during XMIT must not touch the cache
    samp[0] = 16'd5; samp[1] = 16'd7;
    s0 = start_cnt;
    load_frame(16'h0102, 0);
    send(16'hBEEF);
    chk("byp_cache0", 32'(cache_flat[0 +: DW]), 32'd5);
    chk("byp_cache1", 32'(cache_flat[DW +: DW]), 32'd7);
    drain(2'b10, 1, -1);
    chk("byp_starts", 32'(start_cnt - s0), 32'd0);

    // len=0 cases: FFT gives 2 words, bypass forwards the single sample
    samp[0] = 16'h0055;
    load_frame(16'h0000, 2);
    drain(2'b00, 0, -1);
    samp[0] = 16'h0077;
    load_frame(16'h0002, 0);
    drain(2'b10, 0, -1);

    // Reset mid-XMIT, then next word is a header
    samp[0] = 16'h1; samp[1] = 16'h2; samp[2] = 16'h3; samp[3] = 16'h4;
    load_frame(16'h0301, 1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    rstb = 1'b0;
    #1;
    chk("abort_valid", 32'(data_out_valid), 32'd0);
    chk("abort_dout", 32'(data_out), 32'd0);
    chk("abort_busy", 32'(core_busy), 32'd0);
    chk("abort_mode_len", {22'd0, eng_mode, eng_len}, 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    samp[0] = 16'h0011; samp[1] = 16'h0022;
    load_frame(16'h0102, 0);
    chk("post_abort_mode", 32'(eng_mode), 32'd2);
    drain(2'b10, 1, -1);

`ifdef DSP_CORE_TIMEOUT_EN
    send(16'h0000);
    send(16'h0001);
    wait_start();
    repeat (16) @(negedge clk);
    chk("wd_before_busy", 32'(core_busy), 32'd1);
    chk("wd_before_err", 32'(err), 32'd0);
    @(negedge clk);
    chk("wd_err", 32'(err), 32'd3);
    chk("wd_busy", 32'(core_busy), 32'd0);
    send(16'h0000);
    send(16'h0001);
    wait_start();
    repeat (16) @(negedge clk);
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    chk("wd_race_valid", 32'(data_out_valid), 32'd1);
    chk("wd_race_err", 32'(err), 32'd0);
    drain(2'b00, 0, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
